// File: rtl/warp_register_block_pkg.sv
// Shared sizing for the per-warp, per-lane SIMT register file.
package warp_register_block_pkg;

  localparam int unsigned DATA_W     = 64;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned NUM_WARPS  = 8;
  localparam int unsigned NUM_LANES  = 16;
  localparam int unsigned REG_AW     = $clog2(NUM_REGS);
  localparam int unsigned WARP_W     = $clog2(NUM_WARPS);
  localparam int unsigned BANK_DEPTH = NUM_WARPS * NUM_REGS;
  localparam int unsigned BANK_AW    = WARP_W + REG_AW;

  // Flat bank index: warp context in the upper bits, register in the lower bits.
  function automatic logic [BANK_AW-1:0] bank_index(input logic [WARP_W-1:0] warp,
                                                    input logic [REG_AW-1:0] reg_addr);
    return {warp, reg_addr};
  endfunction

endpackage

// File: rtl/register_lane_bank.sv
// One lane's register storage across all warp contexts: one synchronous write
// port and two independent, enable-gated combinational read ports.
module register_lane_bank
  import warp_register_block_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WARP_W-1:0]   warp_sel_i,
  input  logic                we_i,
  input  logic [REG_AW-1:0]   waddr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic                re0_i,
  input  logic [REG_AW-1:0]   raddr0_i,
  output logic [DATA_W-1:0]   rdata0_o,
  input  logic                re1_i,
  input  logic [REG_AW-1:0]   raddr1_i,
  output logic [DATA_W-1:0]   rdata1_o
);

  logic [DATA_W-1:0] mem_q [BANK_DEPTH];

  // Reset clears every context; a write pending at reset assertion is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BANK_DEPTH; i++) begin
        mem_q[BANK_AW'(i)] <= '0;
      end
    end else if (we_i) begin
      mem_q[bank_index(warp_sel_i, waddr_i)] <= wdata_i;
    end
  end

  // No write bypass: a same-address read sees the old word until the edge.
  assign rdata0_o = re0_i ? mem_q[bank_index(warp_sel_i, raddr0_i)] : '0;
  assign rdata1_o = re1_i ? mem_q[bank_index(warp_sel_i, raddr1_i)] : '0;

endmodule

// File: rtl/warp_register_block.sv
// 16-lane SIMT general-purpose register file; fans shared address, warp and
// enable signals out to one register_lane_bank per lane.
module warp_register_block
  import warp_register_block_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WARP_W-1:0]    warp_selector,
  input  logic [NUM_LANES-1:0] write_en,
  input  logic [REG_AW-1:0]    waddr,
  input  logic [DATA_W-1:0]    wdata_0,
  input  logic [DATA_W-1:0]    wdata_1,
  input  logic [DATA_W-1:0]    wdata_2,
  input  logic [DATA_W-1:0]    wdata_3,
  input  logic [DATA_W-1:0]    wdata_4,
  input  logic [DATA_W-1:0]    wdata_5,
  input  logic [DATA_W-1:0]    wdata_6,
  input  logic [DATA_W-1:0]    wdata_7,
  input  logic [DATA_W-1:0]    wdata_8,
  input  logic [DATA_W-1:0]    wdata_9,
  input  logic [DATA_W-1:0]    wdata_10,
  input  logic [DATA_W-1:0]    wdata_11,
  input  logic [DATA_W-1:0]    wdata_12,
  input  logic [DATA_W-1:0]    wdata_13,
  input  logic [DATA_W-1:0]    wdata_14,
  input  logic [DATA_W-1:0]    wdata_15,
  input  logic [NUM_LANES-1:0] read_en_0,
  input  logic [REG_AW-1:0]    raddr_0,
  input  logic [NUM_LANES-1:0] read_en_1,
  input  logic [REG_AW-1:0]    raddr_1,
  output logic [DATA_W-1:0]    rdata_0_0,
  output logic [DATA_W-1:0]    rdata_0_1,
  output logic [DATA_W-1:0]    rdata_0_2,
  output logic [DATA_W-1:0]    rdata_0_3,
  output logic [DATA_W-1:0]    rdata_0_4,
  output logic [DATA_W-1:0]    rdata_0_5,
  output logic [DATA_W-1:0]    rdata_0_6,
  output logic [DATA_W-1:0]    rdata_0_7,
  output logic [DATA_W-1:0]    rdata_0_8,
  output logic [DATA_W-1:0]    rdata_0_9,
  output logic [DATA_W-1:0]    rdata_0_10,
  output logic [DATA_W-1:0]    rdata_0_11,
  output logic [DATA_W-1:0]    rdata_0_12,
  output logic [DATA_W-1:0]    rdata_0_13,
  output logic [DATA_W-1:0]    rdata_0_14,
  output logic [DATA_W-1:0]    rdata_0_15,
  output logic [DATA_W-1:0]    rdata_1_0,
  output logic [DATA_W-1:0]    rdata_1_1,
  output logic [DATA_W-1:0]    rdata_1_2,
  output logic [DATA_W-1:0]    rdata_1_3,
  output logic [DATA_W-1:0]    rdata_1_4,
  output logic [DATA_W-1:0]    rdata_1_5,
  output logic [DATA_W-1:0]    rdata_1_6,
  output logic [DATA_W-1:0]    rdata_1_7,
  output logic [DATA_W-1:0]    rdata_1_8,
  output logic [DATA_W-1:0]    rdata_1_9,
  output logic [DATA_W-1:0]    rdata_1_10,
  output logic [DATA_W-1:0]    rdata_1_11,
  output logic [DATA_W-1:0]    rdata_1_12,
  output logic [DATA_W-1:0]    rdata_1_13,
  output logic [DATA_W-1:0]    rdata_1_14,
  output logic [DATA_W-1:0]    rdata_1_15
);

  logic [DATA_W-1:0] wdata  [NUM_LANES];
  logic [DATA_W-1:0] rdata0 [NUM_LANES];
  logic [DATA_W-1:0] rdata1 [NUM_LANES];

  assign wdata[0]  = wdata_0;
  assign wdata[1]  = wdata_1;
  assign wdata[2]  = wdata_2;
  assign wdata[3]  = wdata_3;
  assign wdata[4]  = wdata_4;
  assign wdata[5]  = wdata_5;
  assign wdata[6]  = wdata_6;
  assign wdata[7]  = wdata_7;
  assign wdata[8]  = wdata_8;
  assign wdata[9]  = wdata_9;
  assign wdata[10] = wdata_10;
  assign wdata[11] = wdata_11;
  assign wdata[12] = wdata_12;
  assign wdata[13] = wdata_13;
  assign wdata[14] = wdata_14;
  assign wdata[15] = wdata_15;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    register_lane_bank u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .warp_sel_i (warp_selector),
      .we_i       (write_en[l]),
      .waddr_i    (waddr),
      .wdata_i    (wdata[l]),
      .re0_i      (read_en_0[l]),
      .raddr0_i   (raddr_0),
      .rdata0_o   (rdata0[l]),
      .re1_i      (read_en_1[l]),
      .raddr1_i   (raddr_1),
      .rdata1_o   (rdata1[l])
    );
  end

  assign rdata_0_0  = rdata0[0];
  assign rdata_0_1  = rdata0[1];
  assign rdata_0_2  = rdata0[2];
  assign rdata_0_3  = rdata0[3];
  assign rdata_0_4  = rdata0[4];
  assign rdata_0_5  = rdata0[5];
  assign rdata_0_6  = rdata0[6];
  assign rdata_0_7  = rdata0[7];
  assign rdata_0_8  = rdata0[8];
  assign rdata_0_9  = rdata0[9];
  assign rdata_0_10 = rdata0[10];
  assign rdata_0_11 = rdata0[11];
  assign rdata_0_12 = rdata0[12];
  assign rdata_0_13 = rdata0[13];
  assign rdata_0_14 = rdata0[14];
  assign rdata_0_15 = rdata0[15];

  assign rdata_1_0  = rdata1[0];
  assign rdata_1_1  = rdata1[1];
  assign rdata_1_2  = rdata1[2];
  assign rdata_1_3  = rdata1[3];
  assign rdata_1_4  = rdata1[4];
  assign rdata_1_5  = rdata1[5];
  assign rdata_1_6  = rdata1[6];
  assign rdata_1_7  = rdata1[7];
  assign rdata_1_8  = rdata1[8];
  assign rdata_1_9  = rdata1[9];
  assign rdata_1_10 = rdata1[10];
  assign rdata_1_11 = rdata1[11];
  assign rdata_1_12 = rdata1[12];
  assign rdata_1_13 = rdata1[13];
  assign rdata_1_14 = rdata1[14];
  assign rdata_1_15 = rdata1[15];

endmodule

// File: tb/tb_warp_register_block.sv
// Self-checking bench for warp_register_block: a mem[warp][reg][lane] array
// model is compared against every read output on each falling clock edge.
module tb_warp_register_block;

  logic        clk;
  logic        rst_n;
  logic [2:0]  warp_selector;
  logic [15:0] write_en;
  logic [4:0]  waddr;
  logic [63:0] wdata [16];
  logic [15:0] read_en_0;
  logic [4:0]  raddr_0;
  logic [15:0] read_en_1;
  logic [4:0]  raddr_1;
  logic [63:0] rd0 [16];
  logic [63:0] rd1 [16];

  logic [63:0] model [8][32][16];
  int unsigned n_pass;
  int unsigned n_total;
  logic        checking;

  warp_register_block dut (
    .clk(clk), .rst_n(rst_n), .warp_selector(warp_selector),
    .write_en(write_en), .waddr(waddr),
    .wdata_0(wdata[0]),   .wdata_1(wdata[1]),   .wdata_2(wdata[2]),   .wdata_3(wdata[3]),
    .wdata_4(wdata[4]),   .wdata_5(wdata[5]),   .wdata_6(wdata[6]),   .wdata_7(wdata[7]),
    .wdata_8(wdata[8]),   .wdata_9(wdata[9]),   .wdata_10(wdata[10]), .wdata_11(wdata[11]),
    .wdata_12(wdata[12]), .wdata_13(wdata[13]), .wdata_14(wdata[14]), .wdata_15(wdata[15]),
    .read_en_0(read_en_0), .raddr_0(raddr_0), .read_en_1(read_en_1), .raddr_1(raddr_1),
    .rdata_0_0(rd0[0]),   .rdata_0_1(rd0[1]),   .rdata_0_2(rd0[2]),   .rdata_0_3(rd0[3]),
    .rdata_0_4(rd0[4]),   .rdata_0_5(rd0[5]),   .rdata_0_6(rd0[6]),   .rdata_0_7(rd0[7]),
    .rdata_0_8(rd0[8]),   .rdata_0_9(rd0[9]),   .rdata_0_10(rd0[10]), .rdata_0_11(rd0[11]),
    .rdata_0_12(rd0[12]), .rdata_0_13(rd0[13]), .rdata_0_14(rd0[14]), .rdata_0_15(rd0[15]),
    .rdata_1_0(rd1[0]),   .rdata_1_1(rd1[1]),   .rdata_1_2(rd1[2]),   .rdata_1_3(rd1[3]),
    .rdata_1_4(rd1[4]),   .rdata_1_5(rd1[5]),   .rdata_1_6(rd1[6]),   .rdata_1_7(rd1[7]),
    .rdata_1_8(rd1[8]),   .rdata_1_9(rd1[9]),   .rdata_1_10(rd1[10]), .rdata_1_11(rd1[11]),
    .rdata_1_12(rd1[12]), .rdata_1_13(rd1[13]), .rdata_1_14(rd1[14]), .rdata_1_15(rd1[15])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] expect_rd(input logic en, input logic [4:0] a, input int lane);
    return en ? model[warp_selector][a][lane] : 64'h0;
  endfunction

  task automatic clear_model();
    for (int w = 0; w < 8; w++)
      for (int r = 0; r < 32; r++)
        for (int l = 0; l < 16; l++)
          model[w][r][l] = 64'h0;
  endtask

  // Advance one edge; the model commits the write the DUT sees at that edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n)
      for (int l = 0; l < 16; l++)
        if (write_en[l]) model[warp_selector][waddr][l] = wdata[l];
    #1;
  endtask

  task automatic set_write(input logic [2:0] w, input logic [4:0] a, input logic [15:0] en);
    warp_selector = w;
    waddr         = a;
    write_en      = en;
    for (int l = 0; l < 16; l++) wdata[l] = rand64();
  endtask

  task automatic set_read(input logic [15:0] e0, input logic [4:0] a0,
                          input logic [15:0] e1, input logic [4:0] a1);
    read_en_0 = e0; raddr_0 = a0;
    read_en_1 = e1; raddr_1 = a1;
  endtask

  // Compare every output against the model whenever checking is active.
  always @(negedge clk) begin
    if (checking) begin
      for (int l = 0; l < 16; l++) begin
        chk($sformatf("rd0_lane%0d", l), rd0[l], expect_rd(read_en_0[l], raddr_0, l));
        chk($sformatf("rd1_lane%0d", l), rd1[l], expect_rd(read_en_1[l], raddr_1, l));
      end
    end
  end

  initial begin
    logic [63:0] prior_hi;
    logic [63:0] lit;
    n_pass = 0;
    n_total = 0;
    checking = 1'b0;
    clear_model();
    rst_n = 1'b0;
    warp_selector = '0; write_en = '0; waddr = '0;
    for (int l = 0; l < 16; l++) wdata[l] = '0;
    set_read(16'hFFFF, 5'd0, 16'hFFFF, 5'd0);
    #1;
    checking = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset state: every register of warp 0 reads zero on both ports.
    for (int r = 0; r < 32; r++) begin
      set_read(16'hFFFF, 5'(r), 16'hFFFF, 5'(r));
      tick();
    end

    // Full sweep with port 0 alone, port 1 alone, then both at one address.
    for (int w = 0; w < 8; w++) begin
      for (int r = 0; r < 32; r++) begin
        set_write(3'(w), 5'(r), 16'hFFFF);
        set_read(16'h0, 5'd0, 16'h0, 5'd0);
        tick();
        write_en = 16'h0;
        set_read(16'hFFFF, 5'(r), 16'h0, 5'(r));
        tick();
        set_read(16'h0, 5'(r), 16'hFFFF, 5'(r));
        tick();
        set_read(16'hFFFF, 5'(r), 16'hFFFF, 5'(r));
        tick();
      end
    end

    // Per-lane write enable on warp 2, reg 5.
    prior_hi = model[2][5][8];
    set_write(3'd2, 5'd5, 16'h00FF);
    for (int l = 0; l < 16; l++) wdata[l] = 64'hAAAA_0000_0000_0001;
    tick();
    write_en = 16'h0;
    set_read(16'hFFFF, 5'd5, 16'hFFFF, 5'd5);
    #1;
    chk("lane_en_lo", rd0[0], 64'hAAAA_0000_0000_0001);
    chk("lane_en_lo7", rd1[7], 64'hAAAA_0000_0000_0001);
    chk("lane_en_hi", rd0[8], prior_hi);
    lit = 64'hAAAA_0000_0000_0001;
    if (prior_hi === lit) $display("FAIL lane_en_prior: got %h expected not %h", prior_hi, lit);
    tick();

    // Warp isolation on reg 3.
    set_write(3'd1, 5'd3, 16'hFFFF);
    for (int l = 0; l < 16; l++) wdata[l] = 64'h1111;
    tick();
    set_write(3'd6, 5'd3, 16'hFFFF);
    for (int l = 0; l < 16; l++) wdata[l] = 64'h2222;
    tick();
    write_en = 16'h0;
    for (int w = 0; w < 8; w++) begin
      warp_selector = 3'(w);
      set_read(16'hFFFF, 5'd3, 16'hFFFF, 5'd3);
      tick();
      if (w == 1) chk("warp1_r3", rd0[4], 64'h1111);
      if (w == 6) chk("warp6_r3", rd1[12], 64'h2222);
    end

    // Read-enable gating: only rdata_0_0 and rdata_1_15 may be driven.
    warp_selector = 3'd0;
    set_read(16'h0001, 5'd10, 16'h8000, 5'd20);
    #1;
    chk("gate_rd0_1", rd0[1], 64'h0);
    chk("gate_rd1_0", rd1[0], 64'h0);
    chk("gate_rd0_0", rd0[0], model[0][10][0]);
    tick();

    // Same-cycle read/write of reg 7: old value before the edge, new after.
    set_write(3'd4, 5'd7, 16'hFFFF);
    for (int l = 0; l < 16; l++) wdata[l] = 64'h5;
    tick();
    for (int l = 0; l < 16; l++) wdata[l] = 64'h9;
    set_read(16'hFFFF, 5'd7, 16'hFFFF, 5'd7);
    #1;
    chk("rdw_before", rd0[3], 64'h5);
    tick();
    write_en = 16'h0;
    chk("rdw_after", rd1[3], 64'h9);
    chk("rdw_after0", rd0[15], 64'h9);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      set_write(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 16'($urandom));
      set_read(16'($urandom), 5'($urandom_range(0, 31)), 16'($urandom), 5'($urandom_range(0, 31)));
      tick();
    end

    // Register 0 is writable, not hardwired to zero.
    set_write(3'd3, 5'd0, 16'hFFFF);
    for (int l = 0; l < 16; l++) wdata[l] = 64'hDEAD_BEEF_0000_0042;
    tick();
    write_en = 16'h0;
    set_read(16'hFFFF, 5'd0, 16'h0, 5'd0);
    #1;
    chk("reg0_writable", rd0[9], 64'hDEAD_BEEF_0000_0042);
    tick();

    // Reset mid-operation with a write pending: write dropped, contents cleared.
    set_write(3'd5, 5'd9, 16'hFFFF);
    set_read(16'hFFFF, 5'd9, 16'hFFFF, 5'd0);
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("async_reset_clear", rd1[2], 64'h0);
    tick();
    rst_n = 1'b1;
    write_en = 16'h0;
    tick();
    chk("reset_drops_write", rd0[6], 64'h0);
    tick();

    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/warp_register_block.md
Name: warp_register_block

Overview:
- Per-warp, per-lane general-purpose register file for the SIMT core datapath.
- Sits between operand collection/issue and writeback.
- 16 lanes, each holding NUM_WARPS x NUM_REGS words of DATA_W bits.
- One synchronous write port and two asynchronous read ports, all shared across lanes with per-lane enables; warp_selector chooses the active warp context.

Parameters:
- DATA_W, 64, register word width.
- NUM_REGS, 32, architectural registers per warp per lane (address width log2 = 5).
- NUM_WARPS, 8, warp contexts (warp_selector width log2 = 3).
- Lane count is fixed at 16 by the port list.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- warp_selector  in  3  warp context for all reads and writes this cycle.
- write_en  in  16  per-lane write enable; bit i = lane i.
- waddr  in  5  write register address.
- wdata_0 .. wdata_15  in  64 each  write data for lanes 0..15.
- read_en_0  in  16  per-lane enable, read port 0.
- raddr_0  in  5  read address, port 0.
- read_en_1  in  16  per-lane enable, read port 1.
- raddr_1  in  5  read address, port 1.
- rdata_0_0 .. rdata_0_15  out  64 each  port-0 data for lanes 0..15.
- rdata_1_0 .. rdata_1_15  out  64 each  port-1 data for lanes 0..15.

Behaviour:
- Storage: mem[warp][reg][lane], DATA_W bits each.
- Reset: while rst_n=0 (asynchronous assertion), every storage word is 0. Since read outputs are combinational, all rdata outputs read 0 during and after reset until written.
- Write: on rising clk with rst_n=1, for each lane i with write_en[i]=1, mem[warp_selector][waddr][i] <= wdata_i. Lanes with write_en[i]=0 are unchanged. Write latency is 1 edge.
- Read port p, lane i (combinational, zero latency):
  - If read_en_p[i]=1: rdata_p_i = mem[warp_selector][raddr_p][i].
  - Else rdata_p_i = 0.
- Ports 0 and 1 are fully independent. They may use the same or different addresses simultaneously, with no conflict.
- Read during write, same address: the read returns the old contents until the clock edge, then the new value (no bypass).
- Register 0 is an ordinary writable register; it is not hardwired to zero.
- warp_selector change: takes effect immediately for reads and at the next edge for writes. Other warps' contents are never disturbed.
- Reset mid-operation: a pending write is discarded and contents clear immediately.

Decomposition:
- Shared package: DATA_W, NUM_REGS, NUM_WARPS, NUM_LANES=16, derived widths REG_AW=5 and WARP_W=3.
- Sub-module register_lane_bank, instantiated 16 times. Each instance provides:
  - one lane's storage (NUM_WARPS*NUM_REGS words);
  - the write port with a 1-bit enable;
  - two read ports with 1-bit enables.
- The top only fans out the shared address, warp and enable signals and the per-lane data.

Test Plan:
- Reset: hold rst_n=0, then release; read_en_0=read_en_1=16'hFFFF, raddr=0..31 with warp 0 -> all 32 rdata outputs = 0.
- Full sweep: for warp 0..7 and reg 0..31, write distinct random values to all 16 lanes (write_en=16'hFFFF). Next cycle:
  - read via port 0 alone, then port 1 alone, then both ports at the same address;
  - expected: each lane returns its written word; outputs of the disabled port = 0.
- Per-lane enable: write 64'hAAAA_0000_0000_0001 to reg 5, warp 2, with write_en=16'h00FF -> lanes 0..7 read the new value, lanes 8..15 keep their prior value.
- Warp isolation: write 64'h1111 to reg 3 in warp 1 and 64'h2222 to reg 3 in warp 6 -> selecting warp 1 reads 64'h1111, warp 6 reads 64'h2222, other warps unchanged.
- Read-enable gating: read_en_0=16'h0001, read_en_1=16'h8000 -> only rdata_0_0 and rdata_1_15 are non-zero; all others = 0.
- Same-cycle read/write: reg 7 holds 64'h5; write 64'h9 while reading reg 7 -> reads 64'h5 before the edge and 64'h9 after.
